adc_frame_packer: RTL
=====================

ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, meaning input clock frequency in MHz.
REQ-002 SHALL have parameter SEND_FRE, default 2, meaning frames per second.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port adc0809_data  input  [7:0][7:0]  latest 8-channel ADC0809 result, index = channel.
REQ-006 SHALL have port tx_data  output  8  byte offered to the UART byte transmitter.
REQ-007 SHALL have port tx_valid  output  1  tx_data holds a valid byte.
REQ-008 SHALL have port tx_ready  input  1  UART transmitter accepts a byte this cycle.
REQ-009 SHALL have port busy  output  1  high while a frame is in flight.
REQ-010 SHALL have port overrun  output  1  sticky: a send tick was dropped.

Function
REQ-011 SHALL generate a one-cycle send tick every TICK_CYCLES = CLK_FRE*1_000_000/SEND_FRE clocks, free-running, independent of FSM state.
REQ-012 SHALL implement FSM states IDLE and SEND only.
REQ-013 IDLE + tick: SHALL latch all 8 channels of adc0809_data into shadow registers and go to SEND in the same edge; tx_valid high the next cycle.
REQ-014 Frame SHALL be 12 bytes in order: 0xAA, 0x55, seq, ch0..ch7, csum.
REQ-015 seq SHALL be an 8-bit frame counter, 0x00 after reset, incremented after each completed frame, wrapping 0xFF -> 0x00.
REQ-016 csum SHALL be the modulo-256 sum of seq and ch0..ch7 (9 bytes); headers excluded.
REQ-017 A byte SHALL be transferred on a rising edge where tx_valid && tx_ready; tx_data and tx_valid SHALL stay stable until then.
REQ-018 After transfer of byte 11, SHALL return to IDLE with tx_valid low the next cycle; no idle gap required between other bytes.
REQ-019 busy SHALL equal (state == SEND).
REQ-020 Changes on adc0809_data during SEND SHALL NOT affect the frame in flight.
REQ-021 Tick while in SEND (including the cycle byte 11 transfers) SHALL be dropped, set overrun, and not start or queue a frame.
REQ-022 overrun SHALL clear only on reset.

Reset
REQ-023 On rst_n low, asynchronously: state IDLE, tx_valid 0, tx_data 0x00, busy 0, overrun 0, seq 0x00, byte index 0, tick counter 0, shadow registers 0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; after release the first frame starts at 0xAA with seq 0x00.

Structure
REQ-025 Shared package adc_frame_pkg SHALL hold: header constants 0xAA/0x55, FRAME_LEN = 12, state enum, byte-index type.
REQ-026 Tick generation SHALL be one sub-module send_rate_timer (parameters CLK_FRE, SEND_FRE; outputs tick).
REQ-027 Sub-module SHALL use the same clk/rst_n, 32-bit counter, tick when counter == TICK_CYCLES-1 then wrap to 0.

Verification (CLK_FRE=1, SEND_FRE=100000 -> TICK_CYCLES=10)
REQ-028 ch i = i+1, tx_ready=1 -> bytes AA 55 00 01 02 03 04 05 06 07 08 24; busy high exactly 12 cycles.
REQ-029 tx_ready low 5 cycles while byte 3 offered -> tx_data held 0x01, tx_valid held 1, then sequence resumes unchanged.
REQ-030 All channels 0xFF, run 256 frames -> frame 256 has seq 0xFF, csum 0xF7; frame 257 seq 0x00, csum 0xF8.
REQ-031 adc0809_data changed to 0x55 on all channels one cycle after latch -> in-flight frame still carries latched values; next frame carries 0x55.
REQ-032 tx_ready held low 25 cycles -> overrun = 1, only one frame emitted, seq increments by 1.
REQ-033 rst_n pulsed low while byte 6 offered -> tx_valid 0 same cycle; next frame starts 0xAA 0x55 0x00.

Source files
------------

// File: rtl/adc_frame_pkg.sv
// adc_frame_pkg: shared constants and types for the ADC frame packer.
package adc_frame_pkg;
    localparam logic [7:0] HDR0 = 8'hAA;
    localparam logic [7:0] HDR1 = 8'h55;
    localparam int FRAME_LEN = 12;

    typedef enum logic {IDLE, SEND} state_t;
    typedef logic [3:0] idx_t;

    localparam idx_t LAST_IDX = idx_t'(FRAME_LEN - 1);
endpackage

// File: rtl/send_rate_timer.sv
// send_rate_timer: free-running counter producing a one-cycle tick every TICK_CYCLES clocks.
module send_rate_timer #(
    parameter int CLK_FRE  = 50,
    parameter int SEND_FRE = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam logic [31:0] TICK_CYCLES = 32'(64'(CLK_FRE) * 64'd1000000 / 64'(SEND_FRE));

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        tick  = cnt_q == TICK_CYCLES - 32'd1;
        cnt_d = tick ? '0 : cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: periodically snapshots 8 ADC channels and streams them as a
// 12-byte frame (AA 55 seq ch0..ch7 csum) over a valid/ready byte interface.
module adc_frame_packer
    import adc_frame_pkg::*;
#(
    parameter int CLK_FRE  = 50,
    parameter int SEND_FRE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0][7:0] adc0809_data,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            busy,
    output logic            overrun
);
    state_t          state_q, state_d;
    idx_t            idx_q, idx_d;
    logic [7:0]      seq_q, seq_d;
    logic [7:0][7:0] shadow_q, shadow_d;
    logic            overrun_q, overrun_d;
    logic            tick;
    logic [7:0]      csum;
    logic [7:0]      ch_byte;

    send_rate_timer #(.CLK_FRE(CLK_FRE), .SEND_FRE(SEND_FRE)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        shadow_d  = shadow_q;
        overrun_d = overrun_q | (tick && state_q == SEND);
        busy      = state_q == SEND;
        tx_valid  = busy;
        csum      = seq_q;
        for (int i = 0; i < 8; i++) csum = csum + shadow_q[i];
        ch_byte   = shadow_q[3'(idx_q - idx_t'(3))];
        tx_data   = !busy         ? 8'h00 :
                    idx_q == 4'd0 ? HDR0  :
                    idx_q == 4'd1 ? HDR1  :
                    idx_q == 4'd2 ? seq_q :
                    idx_q == LAST_IDX ? csum : ch_byte;
        // A tick seen while sending is only recorded in overrun, never queued.
        if (state_q == IDLE) begin
            if (tick) begin
                state_d  = SEND;
                idx_d    = '0;
                shadow_d = adc0809_data;
            end
        end else if (tx_ready) begin
            if (idx_q == LAST_IDX) begin
                state_d = IDLE;
                idx_d   = '0;
                seq_d   = seq_q + 8'd1;
            end else begin
                idx_d = idx_q + idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            seq_q     <= '0;
            shadow_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            shadow_q  <= shadow_d;
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
endmodule
